// File: rtl/new_feat_write_arbiter.sv
// new_feat_write_arbiter: round-robin arbiter that funnels NUM_REQ lane feature vectors into one BRAM write port.
// Define NEW_FEAT_ARB_DUP_CHK_EN to track written subgraphs and suppress duplicate bursts (dup_err).
module new_feat_write_arbiter #(
    parameter  int NUM_REQ            = 4,
    parameter  int NUM_FEATURE_OUT    = 16,
    parameter  int NEW_FEATURE_WIDTH  = 32,
    parameter  int NUM_SUBGRAPHS      = 2708,
    localparam int SG_IDX_W           = $clog2(NUM_SUBGRAPHS),
    localparam int REQ_W              = $clog2(NUM_REQ),
    localparam int NEW_FEATURE_ADDR_W = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT)
) (
    input  logic                                                           clk,
    input  logic                                                           rst,
    input  logic [NUM_REQ-1:0][NUM_FEATURE_OUT-1:0][NEW_FEATURE_WIDTH-1:0] req_feat,
    input  logic [NUM_REQ-1:0][SG_IDX_W-1:0]                               req_sg_idx,
    input  logic [NUM_REQ-1:0]                                             req_vld,
    output logic [NUM_REQ-1:0]                                             req_rdy,
    output logic [NEW_FEATURE_ADDR_W-1:0]                                  feat_bram_addra,
    output logic [NEW_FEATURE_WIDTH-1:0]                                   feat_bram_din,
    output logic                                                           feat_bram_ena,
    output logic                                                           range_err,
    output logic                                                           dup_err,
    output logic                                                           gat_ready
);

    localparam int          CNT_W  = $clog2(NUM_FEATURE_OUT);
    localparam int          DONE_W = $clog2(NUM_SUBGRAPHS + 1);
    localparam int unsigned NREQ_U = NUM_REQ;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_FEATURE_OUT - 1);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [REQ_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [DONE_W-1:0] done_q, done_d;
    logic [NUM_FEATURE_OUT-1:0][NEW_FEATURE_WIDTH-1:0] feat_q, feat_d;
    logic suppress_q, suppress_d;
    logic ena_q, ena_d;
    logic [NEW_FEATURE_ADDR_W-1:0] addr_q, addr_d;
    logic [NEW_FEATURE_WIDTH-1:0]  din_q, din_d;
    logic range_err_q, range_err_d;
    logic gat_q, gat_d;

    logic             accept_ok, any_vld, hs, last_beat, inc_done;
    logic [REQ_W-1:0] grant, idx;
    logic [SG_IDX_W-1:0] in_sg;
    logic [NUM_FEATURE_OUT-1:0][NEW_FEATURE_WIDTH-1:0] in_feat;
    logic in_range, in_dup, in_bad;

    // Round-robin scan starting at rr_ptr; first valid lane wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        any_vld = 1'b0;
        for (int unsigned i = 0; i < NREQ_U; i++) begin
            idx = REQ_W'((32'(rr_ptr_q) + i) % NREQ_U);
            if (!any_vld && req_vld[idx]) begin
                any_vld = 1'b1;
                grant   = idx;
            end
        end
    end

    assign accept_ok = (state_q == IDLE) || (cnt_q == LAST);
    assign hs        = accept_ok && any_vld;
    assign req_rdy   = hs ? (NUM_REQ'(1) << grant) : '0;

    assign in_sg    = req_sg_idx[grant];
    assign in_feat  = req_feat[grant];
    assign in_range = {1'b0, in_sg} < (SG_IDX_W + 1)'(NUM_SUBGRAPHS);
    assign in_bad   = !in_range || in_dup;

    assign last_beat = (state_q == WRITE) && (cnt_q == LAST);
    assign inc_done  = last_beat && !suppress_q;

`ifdef NEW_FEAT_ARB_DUP_CHK_EN
    logic [NUM_SUBGRAPHS-1:0] map_q, map_d;
    logic dup_err_q;

    assign in_dup = in_range && map_q[in_sg];

    always_comb begin
        map_d = map_q;
        if (hs && in_range) map_d[in_sg] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            map_q     <= '0;
            dup_err_q <= 1'b0;
        end else begin
            map_q     <= map_d;
            dup_err_q <= dup_err_q | (hs && in_dup);
        end
    end

    assign dup_err = dup_err_q;
`else
    assign in_dup  = 1'b0;
    assign dup_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (hs) state_d = WRITE;
            WRITE:   if (cnt_q == LAST && !hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output words are produced one cycle ahead: the handshake edge already loads word 0,
    // and feat_q holds the remaining words shifted so the next one always sits in the top slot.
    always_comb begin
        cnt_d       = cnt_q;
        rr_ptr_d    = rr_ptr_q;
        feat_d      = feat_q;
        suppress_d  = suppress_q;
        ena_d       = 1'b0;
        addr_d      = addr_q;
        din_d       = din_q;
        range_err_d = range_err_q | (hs && !in_range);
        done_d      = done_q;
        gat_d       = gat_q;
        if (inc_done && done_q != DONE_W'(NUM_SUBGRAPHS)) done_d = done_q + 1'b1;
        if (inc_done && done_q == DONE_W'(NUM_SUBGRAPHS - 1)) gat_d = 1'b1;
        if (hs) begin
            cnt_d      = '0;
            rr_ptr_d   = REQ_W'((32'(grant) + 32'd1) % NREQ_U);
            suppress_d = in_bad;
            ena_d      = !in_bad;
            addr_d     = NEW_FEATURE_ADDR_W'(in_sg) * NEW_FEATURE_ADDR_W'(NUM_FEATURE_OUT);
            din_d      = in_feat[NUM_FEATURE_OUT-1];
            feat_d     = in_feat << NEW_FEATURE_WIDTH;
        end else if (state_q == WRITE && cnt_q != LAST) begin
            cnt_d  = cnt_q + 1'b1;
            ena_d  = !suppress_q;
            addr_d = addr_q + 1'b1;
            din_d  = feat_q[NUM_FEATURE_OUT-1];
            feat_d = feat_q << NEW_FEATURE_WIDTH;
        end else if (last_beat) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            rr_ptr_q    <= '0;
            feat_q      <= '0;
            suppress_q  <= 1'b0;
            ena_q       <= 1'b0;
            addr_q      <= '0;
            din_q       <= '0;
            range_err_q <= 1'b0;
            done_q      <= '0;
            gat_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            feat_q      <= feat_d;
            suppress_q  <= suppress_d;
            ena_q       <= ena_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            range_err_q <= range_err_d;
            done_q      <= done_d;
            gat_q       <= gat_d;
        end
    end

    assign feat_bram_ena   = ena_q;
    assign feat_bram_addra = addr_q;
    assign feat_bram_din   = din_q;
    assign range_err       = range_err_q;
    assign gat_ready       = gat_q;

endmodule

// File: tb/tb_new_feat_write_arbiter.sv
// Scoreboard bench for new_feat_write_arbiter (NUM_SUBGRAPHS shrunk to 6 so completion and range cases are reachable).
module tb_new_feat_write_arbiter;

    localparam int NR  = 4;
    localparam int NF  = 16;
    localparam int W   = 32;
    localparam int NS  = 6;
    localparam int SGW = $clog2(NS);
    localparam int AW  = $clog2(NS * NF);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [NR-1:0][NF-1:0][W-1:0] req_feat   = '0;
    logic [NR-1:0][SGW-1:0]       req_sg_idx = '0;
    logic [NR-1:0]                req_vld    = '0;
    logic [NR-1:0]                req_rdy;
    logic [AW-1:0]                feat_bram_addra;
    logic [W-1:0]                 feat_bram_din;
    logic                         feat_bram_ena, range_err, dup_err, gat_ready;

    always #5 clk = ~clk;

    new_feat_write_arbiter #(
        .NUM_REQ(NR), .NUM_FEATURE_OUT(NF), .NEW_FEATURE_WIDTH(W), .NUM_SUBGRAPHS(NS)
    ) dut (
        .clk(clk), .rst(rst),
        .req_feat(req_feat), .req_sg_idx(req_sg_idx), .req_vld(req_vld), .req_rdy(req_rdy),
        .feat_bram_addra(feat_bram_addra), .feat_bram_din(feat_bram_din), .feat_bram_ena(feat_bram_ena),
        .range_err(range_err), .dup_err(dup_err), .gat_ready(gat_ready)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state, all describing the current cycle
    int m_rem = 0, m_rr = 0, m_done = 0, hs_cnt = 0;
    bit m_ok = 0, m_gat = 0, m_rerr = 0, m_derr = 0;
    bit m_map [NS];
    int q_addr [$];
    logic [W-1:0] q_din [$];
    int glog [$];

    always @(negedge clk) begin
        logic [NR-1:0] exp_rdy;
        int g, s, l;
        bit inr, dup;
        exp_rdy = '0;
        g = -1;
        if (m_rem <= 1)
            for (int i = 0; i < NR; i++) begin
                l = (m_rr + i) % NR;
                if (g < 0 && req_vld[l]) g = l;
            end
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_rdy", req_rdy, exp_rdy);
        check("ena", feat_bram_ena, (m_rem > 0) && m_ok);
        if (feat_bram_ena) begin
            if (q_addr.size() == 0) check("unexpected_write", 1, 0);
            else begin
                check("addra", feat_bram_addra, q_addr.pop_front());
                check("din", feat_bram_din, q_din.pop_front());
            end
        end
        check("gat_ready", gat_ready, m_gat);
        check("range_err", range_err, m_rerr);
        check("dup_err", dup_err, m_derr);
        if (rst) begin
            m_rem = 0; m_rr = 0; m_done = 0; m_ok = 0; m_gat = 0; m_rerr = 0; m_derr = 0;
            foreach (m_map[i]) m_map[i] = 0;
            q_addr.delete();
            q_din.delete();
        end else begin
            if (m_rem == 1 && m_ok) begin
                if (m_done < NS) m_done++;
                if (m_done == NS) m_gat = 1;
            end
            if (g >= 0) begin
                s   = int'(req_sg_idx[g]);
                inr = s < NS;
`ifdef NEW_FEAT_ARB_DUP_CHK_EN
                dup = inr && m_map[s];
                if (inr) m_map[s] = 1;
`else
                dup = 0;
`endif
                if (!inr) m_rerr = 1;
                if (dup) m_derr = 1;
                m_ok = inr && !dup;
                if (m_ok)
                    for (int k = 0; k < NF; k++) begin
                        q_addr.push_back(s * NF + k);
                        q_din.push_back(req_feat[g][NF-1-k]);
                    end
                m_rr = (g + 1) % NR;
                m_rem = NF;
                glog.push_back(g);
                hs_cnt++;
            end else if (m_rem > 0) m_rem--;
        end
    end

    task automatic set_lane(input int lane, input int sg, input int seed);
        req_sg_idx[lane] = SGW'(sg);
        for (int k = 0; k < NF; k++) req_feat[lane][k] = W'((seed << 8) + k + 1);
    endtask

    task automatic wait_hs(input int lane);
        int n = 0;
        while (n < 200) begin
            @(negedge clk);
            if (req_rdy[lane] && req_vld[lane]) break;
            n++;
        end
        if (n >= 200) check("hs_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    task automatic send(input int lane, input int sg, input int seed);
        set_lane(lane, sg, seed);
        req_vld[lane] = 1'b1;
        wait_hs(lane);
        req_vld[lane] = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (m_rem != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("idle_timeout", 1, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        req_vld = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        glog.delete();
    endtask

    initial begin
        int base, n;
        bit exp_dup;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_ena", feat_bram_ena, 0);
        check("reset_addra", feat_bram_addra, 0);

        // T1 single lane, sg 5, feat[k]=k+1
        send(0, 5, 0);
        wait_idle();
        check("t1_grant", glog.size() > 0 ? glog[0] : -1, 0);

        // T2 all lanes held: expect grants 0,1,2,3,0 back-to-back
        do_reset();
        for (int i = 0; i < NR; i++) set_lane(i, i, i + 1);
        base = hs_cnt;
        req_vld = '1;
        n = 0;
        while (hs_cnt < base + 5 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("t2_timeout", 1, 0);
        req_vld = '0;
        wait_idle();
        check("t2_ngrants", glog.size(), 5);
        for (int i = 0; i < 5; i++) check("t2_order", i < glog.size() ? glog[i] : -1, i % NR);

        // T3 out-of-range subgraph index
        do_reset();
        send(2, NS, 3);
        wait_idle();
        check("t3_range_err", range_err, 1);
        check("t3_gat", gat_ready, 0);

        // T4 completion over all NS subgraphs back-to-back, then one more after gat_ready
        do_reset();
        for (int s = 0; s < NS; s++) begin
            set_lane(1, s, s + 10);
            req_vld[1] = 1'b1;
            wait_hs(1);
        end
        req_vld[1] = 1'b0;
        wait_idle();
        check("t4_gat", gat_ready, 1);
        send(3, 2, 40);
        wait_idle();
        check("t4_gat_sticky", gat_ready, 1);

        // T5 reset at k=7 of a burst, then lane0 must win
        do_reset();
        send(1, 2, 20);
        set_lane(2, 4, 21);
        req_vld[2] = 1'b1;
        wait_hs(2);
        req_vld[2] = 1'b0;
        repeat (7) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("t5_ena", feat_bram_ena, 0);
        check("t5_addra", feat_bram_addra, 0);
        check("t5_din", feat_bram_din, 0);
        @(posedge clk); #1;
        glog.delete();
        set_lane(0, 1, 22);
        set_lane(3, 3, 23);
        req_vld[0] = 1'b1;
        req_vld[3] = 1'b1;
        wait_hs(0);
        req_vld[0] = 1'b0;
        wait_hs(3);
        req_vld[3] = 1'b0;
        wait_idle();
        check("t5_first_grant", glog.size() > 0 ? glog[0] : -1, 0);
        check("t5_second_grant", glog.size() > 1 ? glog[1] : -1, 3);

        // T6 duplicate subgraph index
        do_reset();
        send(0, 3, 30);
        send(0, 3, 31);
        wait_idle();
`ifdef NEW_FEAT_ARB_DUP_CHK_EN
        exp_dup = 1;
`else
        exp_dup = 0;
`endif
        check("t6_dup_err", dup_err, exp_dup);
        check("sb_empty", q_addr.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule
